// File: rtl/memmap_pkg.sv
// Shared definitions for the multi-bank memory map: slot field width,
// slot index type, read-control state encoding and the slot-mapped test.
package memmap_pkg;

  localparam int C_SLOT_W = 3;

  typedef logic [C_SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PEND  = 2'd1,
    RD_ISSUE = 2'd2,
    RD_RET   = 2'd3
  } rd_state_t;

  // A slot is backed by RAM only when it is below the implemented bank count.
  function automatic logic slot_mapped(slot_t slot, int unsigned nbanks);
    return 32'(slot) < nbanks;
  endfunction

endpackage

// File: rtl/cheby_dpssram.sv
// Single-clock dual-port RAM. Port A reads/writes, port B reads only.
// Reads are registered; a same-cycle read of the address being written
// returns the old word.
module cheby_dpssram #(
  parameter int g_data_width = 16,
  parameter int g_addr_width = 6
) (
  input  logic                    clk_i,
  input  logic [g_addr_width-1:0] addr_a_i,
  input  logic [g_data_width-1:0] data_a_i,
  input  logic                    rd_a_i,
  input  logic                    wr_a_i,
  output logic [g_data_width-1:0] data_a_o,
  input  logic [g_addr_width-1:0] addr_b_i,
  input  logic                    rd_b_i,
  output logic [g_data_width-1:0] data_b_o
);

  logic [g_data_width-1:0] mem_q [2**g_addr_width];
  logic [g_data_width-1:0] data_a_q, data_a_d;
  logic [g_data_width-1:0] data_b_q, data_b_d;

  // Read ports hold their last word unless enabled.
  always_comb begin
    data_a_d = rd_a_i ? mem_q[addr_a_i] : data_a_q;
    data_b_d = rd_b_i ? mem_q[addr_b_i] : data_b_q;
  end

  // Storage and read registers; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_a_i) mem_q[addr_a_i] <= data_a_i;
    data_a_q <= data_a_d;
    data_b_q <= data_b_d;
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;

endmodule

// File: rtl/memmap_bank.sv
// One RAM bank of the memory map: a dual-port RAM plus the port-A read
// acknowledge (rack), which is high in the cycle the read word is valid.
module memmap_bank
  import memmap_pkg::*;
#(
  parameter int G_DATA_WIDTH = 16,
  parameter int G_BANK_AW    = 6
) (
  input  logic                    Clk,
  input  logic                    rst_n,
  input  logic [G_BANK_AW-1:0]    addr_a_i,
  input  logic [G_DATA_WIDTH-1:0] dat_a_i,
  input  logic                    rd_a_i,
  input  logic                    wr_a_i,
  output logic [G_DATA_WIDTH-1:0] dat_a_o,
  output logic                    rack_o,
  input  logic [G_BANK_AW-1:0]    addr_b_i,
  input  logic                    rd_b_i,
  output logic [G_DATA_WIDTH-1:0] dat_b_o
);

  logic rack_q, rack_d;

  cheby_dpssram #(
    .g_data_width(G_DATA_WIDTH),
    .g_addr_width(G_BANK_AW)
  ) u_ram (
    .clk_i   (Clk),
    .addr_a_i(addr_a_i),
    .data_a_i(dat_a_i),
    .rd_a_i  (rd_a_i),
    .wr_a_i  (wr_a_i),
    .data_a_o(dat_a_o),
    .addr_b_i(addr_b_i),
    .rd_b_i  (rd_b_i),
    .data_b_o(dat_b_o)
  );

  // Read ack follows the RAM read latency of one cycle.
  always_comb rack_d = rd_a_i;

  // Ack register.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) rack_q <= 1'b0;
    else        rack_q <= rack_d;
  end

  assign rack_o = rack_q;

endmodule

// File: rtl/memmap_nbank.sv
// Multi-bank memory map behind the VME-style slave bus.
// Optional feature: define MEMMAP_ERR_EN to pulse VMEErr with the Done of
// every access to an unmapped slot; otherwise VMEErr is tied low.
//
// Read control states:
//   state    | meaning
//   RD_IDLE  | no read outstanding; a read strobe is issued here directly
//   RD_PEND  | read collided with a write on port A; issue once port is free
//   RD_ISSUE | RAM word valid this cycle, captured into the ack registers
//   RD_RET   | VMERdDone/VMERdData presented
module memmap_nbank
  import memmap_pkg::*;
#(
  parameter int G_NBANKS     = 2,
  parameter int G_DATA_WIDTH = 16,
  parameter int G_BANK_AW    = 6
) (
  input  logic                             Clk,
  input  logic                             rst_n,
  input  logic [G_BANK_AW+4:2]             VMEAddr,
  input  logic [31:0]                      VMEWrData,
  input  logic                             VMERdMem,
  input  logic                             VMEWrMem,
  output logic [31:0]                      VMERdData,
  output logic                             VMERdDone,
  output logic                             VMEWrDone,
  output logic                             VMEErr,
  input  logic [G_NBANKS*G_BANK_AW-1:0]    bank_adr_i,
  input  logic [G_NBANKS-1:0]              bank_rd_i,
  output logic [G_NBANKS*G_DATA_WIDTH-1:0] bank_dat_o
);

  logic                    wr_req_d0_q, wr_req_d0_d;
  logic [G_BANK_AW+4:2]    wr_adr_q, wr_adr_d;
  logic [G_DATA_WIDTH-1:0] wr_dat_q, wr_dat_d;
  rd_state_t               rd_state_q, rd_state_d;
  logic [G_BANK_AW+4:2]    rd_adr_q, rd_adr_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    rd_done_q, rd_done_d;

  slot_t                   wr_slot, rd_slot, pa_slot;
  logic [G_BANK_AW+4:2]    issue_adr, pa_adr;
  logic [G_BANK_AW-1:0]    pa_word;
  logic                    rd_issue;
  logic                    idle;
  logic [G_DATA_WIDTH-1:0] rd_mux;
  logic [G_DATA_WIDTH-1:0] bank_dat_a [G_NBANKS];
  logic [G_NBANKS-1:0]     bank_rack;
  logic                    unused_wr_hi;

  assign unused_wr_hi = ^VMEWrData;

  // Slot decode and port-A address mux; a write in its RAM cycle owns port A.
  always_comb begin
    idle      = (rd_state_q == RD_IDLE);
    wr_slot   = wr_adr_q[G_BANK_AW+4:G_BANK_AW+2];
    rd_slot   = rd_adr_q[G_BANK_AW+4:G_BANK_AW+2];
    issue_adr = (rd_state_q == RD_PEND) ? rd_adr_q : VMEAddr;
    rd_issue  = ((idle && VMERdMem) || (rd_state_q == RD_PEND)) && !wr_req_d0_q;
    pa_adr    = wr_req_d0_q ? wr_adr_q : issue_adr;
    pa_slot   = pa_adr[G_BANK_AW+4:G_BANK_AW+2];
    pa_word   = pa_adr[G_BANK_AW+1:2];
  end

  // Write stage: strobes are dropped while a read is outstanding.
  always_comb begin
    wr_req_d0_d = VMEWrMem && idle;
    wr_adr_d    = wr_req_d0_d ? VMEAddr : wr_adr_q;
    wr_dat_d    = wr_req_d0_d ? VMEWrData[G_DATA_WIDTH-1:0] : wr_dat_q;
  end

  // Read control sequencing.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_adr_d   = rd_adr_q;
    case (rd_state_q)
      RD_IDLE: if (VMERdMem) begin
        rd_adr_d   = VMEAddr;
        rd_state_d = wr_req_d0_q ? RD_PEND : RD_ISSUE;
      end
      RD_PEND:  if (!wr_req_d0_q) rd_state_d = RD_ISSUE;
      RD_ISSUE: rd_state_d = RD_RET;
      default:  rd_state_d = RD_IDLE;
    endcase
  end

  // Read-data mux: only the bank that returned data drives; unmapped reads yield zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < G_NBANKS; k++)
      if (bank_rack[k]) rd_mux = rd_mux | bank_dat_a[k];
    rd_done_d = (rd_state_q == RD_ISSUE);
    rd_data_d = rd_done_d ? 32'(rd_mux) : 32'd0;
  end

  // Bus-side state and ack registers.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_d0_q <= 1'b0;
      wr_adr_q    <= '0;
      wr_dat_q    <= '0;
      rd_state_q  <= RD_IDLE;
      rd_adr_q    <= '0;
      rd_data_q   <= '0;
      rd_done_q   <= 1'b0;
    end else begin
      wr_req_d0_q <= wr_req_d0_d;
      wr_adr_q    <= wr_adr_d;
      wr_dat_q    <= wr_dat_d;
      rd_state_q  <= rd_state_d;
      rd_adr_q    <= rd_adr_d;
      rd_data_q   <= rd_data_d;
      rd_done_q   <= rd_done_d;
    end
  end

  for (genvar k = 0; k < G_NBANKS; k++) begin : g_bank
    memmap_bank #(
      .G_DATA_WIDTH(G_DATA_WIDTH),
      .G_BANK_AW   (G_BANK_AW)
    ) u_bank (
      .Clk     (Clk),
      .rst_n   (rst_n),
      .addr_a_i(pa_word),
      .dat_a_i (wr_dat_q),
      .rd_a_i  (rd_issue && (pa_slot == slot_t'(k))),
      .wr_a_i  (wr_req_d0_q && (wr_slot == slot_t'(k))),
      .dat_a_o (bank_dat_a[k]),
      .rack_o  (bank_rack[k]),
      .addr_b_i(bank_adr_i[k*G_BANK_AW +: G_BANK_AW]),
      .rd_b_i  (bank_rd_i[k]),
      .dat_b_o (bank_dat_o[k*G_DATA_WIDTH +: G_DATA_WIDTH])
    );
  end

  assign VMERdData = rd_data_q;
  assign VMERdDone = rd_done_q;
  assign VMEWrDone = wr_req_d0_q;

`ifdef MEMMAP_ERR_EN
  logic rd_err_q, rd_err_d;

  // Error flag for reads is registered alongside the read ack.
  always_comb rd_err_d = (rd_state_q == RD_ISSUE) && !slot_mapped(rd_slot, G_NBANKS);

  // Read error register.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) rd_err_q <= 1'b0;
    else        rd_err_q <= rd_err_d;
  end

  assign VMEErr = rd_err_q | (wr_req_d0_q && !slot_mapped(wr_slot, G_NBANKS));
`else
  assign VMEErr = 1'b0;
`endif

endmodule

// File: tb/tb_memmap_nbank.sv
module tb_memmap_nbank;

`ifdef MEMMAP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        rst_n;
  logic [10:2] VMEAddr;
  logic [31:0] VMEWrData;
  logic        VMERdMem, VMEWrMem;
  logic [31:0] VMERdData;
  logic        VMERdDone, VMEWrDone, VMEErr;
  logic [11:0] bank_adr_i;
  logic [1:0]  bank_rd_i;
  logic [31:0] bank_dat_o;

  logic [31:0] rd_data8;
  logic        rd_done8, wr_done8, err8;
  logic [15:0] bank_dat8_o;

  always #5 Clk = ~Clk;

  memmap_nbank dut (
    .Clk(Clk), .rst_n(rst_n), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData),
    .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone), .VMEErr(VMEErr),
    .bank_adr_i(bank_adr_i), .bank_rd_i(bank_rd_i), .bank_dat_o(bank_dat_o)
  );

  memmap_nbank #(.G_DATA_WIDTH(8)) dut8 (
    .Clk(Clk), .rst_n(rst_n), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(rd_data8),
    .VMERdDone(rd_done8), .VMEWrDone(wr_done8), .VMEErr(err8),
    .bank_adr_i(bank_adr_i), .bank_rd_i(bank_rd_i), .bank_dat_o(bank_dat8_o)
  );

  typedef struct {
    logic        is_wr;
    logic [2:0]  slot;
    logic [5:0]  word;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp16;
    logic [31:0] exp8;
    logic        err;
  } vec_t;

  vec_t vecs[12];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // One bus access; waits (bounded) for the matching Done and captures outputs.
  task automatic bus_op(input logic is_wr, input logic [2:0] slot, input logic [5:0] word,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd16,
                        output logic [31:0] rd8, output logic err);
    @(posedge Clk); #1;
    VMEAddr   = {slot, word};
    VMEWrData = wd;
    if (is_wr) VMEWrMem = 1'b1;
    else       VMERdMem = 1'b1;
    @(posedge Clk); #1;
    VMEWrMem = 1'b0;
    VMERdMem = 1'b0;
    lat = -1; rd16 = '0; rd8 = '0; err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (is_wr ? VMEWrDone : VMERdDone) begin
        lat = c; rd16 = VMERdData; rd8 = rd_data8; err = VMEErr;
        break;
      end
    end
  endtask

  int          lat, cnt;
  logic [31:0] d16, d8, cap;
  logic        e;

  initial begin
    vecs[0]  = '{1'b1, 3'd1, 6'd5,  32'h0000A5A5, 1, 32'h0,    32'h0,  1'b0};
    vecs[1]  = '{1'b0, 3'd1, 6'd5,  32'h0,        2, 32'hA5A5, 32'hA5, 1'b0};
    vecs[2]  = '{1'b1, 3'd0, 6'd3,  32'h00001234, 1, 32'h0,    32'h0,  1'b0};
    vecs[3]  = '{1'b0, 3'd0, 6'd3,  32'h0,        2, 32'h1234, 32'h34, 1'b0};
    vecs[4]  = '{1'b0, 3'd5, 6'd0,  32'h0,        2, 32'h0,    32'h0,  ERR_EN};
    vecs[5]  = '{1'b1, 3'd7, 6'd5,  32'h0000DEAD, 1, 32'h0,    32'h0,  ERR_EN};
    vecs[6]  = '{1'b0, 3'd1, 6'd5,  32'h0,        2, 32'hA5A5, 32'hA5, 1'b0};
    vecs[7]  = '{1'b1, 3'd0, 6'd63, 32'hFFFFFF7E, 1, 32'h0,    32'h0,  1'b0};
    vecs[8]  = '{1'b0, 3'd0, 6'd63, 32'h0,        2, 32'hFF7E, 32'h7E, 1'b0};
    vecs[9]  = '{1'b1, 3'd1, 6'd0,  32'h0000BEEF, 1, 32'h0,    32'h0,  1'b0};
    vecs[10] = '{1'b0, 3'd1, 6'd0,  32'h0,        2, 32'hBEEF, 32'hEF, 1'b0};
    vecs[11] = '{1'b0, 3'd2, 6'd0,  32'h0,        2, 32'h0,    32'h0,  ERR_EN};

    rst_n = 1'b0; VMEAddr = '0; VMEWrData = '0; VMERdMem = 1'b0; VMEWrMem = 1'b0;
    bank_adr_i = '0; bank_rd_i = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset rddata", VMERdData, 32'h0);
    chk("reset rddone", 32'(VMERdDone), 32'h0);
    chk("reset wrdone", 32'(VMEWrDone), 32'h0);
    chk("reset err", 32'(VMEErr), 32'h0);
    @(posedge Clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus_op(vecs[i].is_wr, vecs[i].slot, vecs[i].word, vecs[i].wdata, lat, d16, d8, e);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      if (!vecs[i].is_wr) begin
        chk($sformatf("v%0d rddata", i), d16, vecs[i].exp16);
        chk($sformatf("v%0d rddata w8", i), d8, vecs[i].exp8);
      end
      chk($sformatf("v%0d err", i), 32'(e), 32'(vecs[i].err));
      @(negedge Clk);
      chk($sformatf("v%0d done width", i), 32'(vecs[i].is_wr ? VMEWrDone : VMERdDone), 32'h0);
    end

    // Collision: read strobe in the write's RAM cycle, same word.
    @(posedge Clk); #1;
    VMEAddr = {3'd1, 6'd9}; VMEWrData = 32'h00005A5A; VMEWrMem = 1'b1;
    @(posedge Clk); #1;
    VMEWrMem = 1'b0; VMERdMem = 1'b1;
    @(negedge Clk);
    chk("coll wrdone", 32'(VMEWrDone), 32'h1);
    @(posedge Clk); #1 VMERdMem = 1'b0;
    lat = -1; cap = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (VMERdDone) begin lat = c; cap = VMERdData; d8 = rd_data8; break; end
    end
    chk("coll latency", 32'(lat), 32'd3);
    chk("coll rddata", cap, 32'h5A5A);
    chk("coll rddata w8", d8, 32'h5A);

    // Port B reads of both banks.
    @(posedge Clk); #1 bank_adr_i = {6'd5, 6'd3}; bank_rd_i = 2'b11;
    @(posedge Clk); #1 bank_rd_i = 2'b00;
    @(negedge Clk);
    chk("portb bank0", 32'(bank_dat_o[15:0]), 32'h1234);
    chk("portb bank1", 32'(bank_dat_o[31:16]), 32'hA5A5);
    chk("portb bank0 w8", 32'(bank_dat8_o[7:0]), 32'h34);

    // Port-B read of the word being written on port A returns the old word.
    @(posedge Clk); #1 VMEAddr = {3'd0, 6'd3}; VMEWrData = 32'h00004321; VMEWrMem = 1'b1;
    @(posedge Clk); #1 VMEWrMem = 1'b0; bank_adr_i = {6'd0, 6'd3}; bank_rd_i = 2'b01;
    @(posedge Clk); #1 bank_rd_i = 2'b00;
    @(negedge Clk);
    chk("portb old data", 32'(bank_dat_o[15:0]), 32'h1234);
    @(posedge Clk); #1 bank_rd_i = 2'b01;
    @(posedge Clk); #1 bank_rd_i = 2'b00;
    @(negedge Clk);
    chk("portb new data", 32'(bank_dat_o[15:0]), 32'h4321);

    // Second read strobe while the first is in flight is dropped.
    @(posedge Clk); #1 VMEAddr = {3'd1, 6'd5}; VMERdMem = 1'b1;
    @(posedge Clk); #1 VMEAddr = {3'd0, 6'd3};
    @(posedge Clk); #1 VMERdMem = 1'b0;
    cnt = 0; cap = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (VMERdDone) begin cnt++; cap = VMERdData; end
    end
    chk("drop done count", 32'(cnt), 32'd1);
    chk("drop rddata", cap, 32'hA5A5);

    // Reset one cycle after a read strobe aborts the read.
    @(posedge Clk); #1 VMEAddr = {3'd1, 6'd0}; VMERdMem = 1'b1;
    @(posedge Clk); #1 VMERdMem = 1'b0; rst_n = 1'b0;
    @(negedge Clk);
    chk("abort rddone", 32'(VMERdDone), 32'h0);
    chk("abort wrdone", 32'(VMEWrDone), 32'h0);
    chk("abort rddata", VMERdData, 32'h0);
    chk("abort err", 32'(VMEErr), 32'h0);
    @(posedge Clk); @(posedge Clk); #1 rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (VMERdDone) cnt++;
    end
    chk("abort no done", 32'(cnt), 32'd0);
    bus_op(1'b0, 3'd1, 6'd0, 32'h0, lat, d16, d8, e);
    chk("post reset latency", 32'(lat), 32'd2);
    chk("post reset rddata", d16, 32'hBEEF);
    chk("post reset rddata w8", d8, 32'hEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
